// File: rtl/register_pipe.sv
// Elastic register pipeline: DEPTH valid/ready stages of WIDTH bits with bubble
// collapse, synchronous flush and a registered occupancy count.
module register_pipe #(
  parameter int unsigned           WIDTH     = 8,
  parameter int unsigned           DEPTH     = 4,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           d_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [WIDTH-1:0]           d_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_v;
  logic [CW-1:0]    r_count;
  logic [DEPTH-1:0] w_adv;
  logic             w_push;
  logic             w_pop;

  // A stage moves when any stage from it to the output is empty or the sink
  // takes the head word; this is the backward adv chain written flat.
  for (genvar k = 0; k < DEPTH; k++) begin : g_adv
    assign w_adv[k] = ready_i | ~(&r_v[DEPTH-1:k]);
  end

  assign ready_o = w_adv[0] & ~flush_i;
  assign valid_o = r_v[DEPTH-1] & ~flush_i;
  assign d_o     = r_data[DEPTH-1];
  assign count_o = r_count;
  assign w_push  = valid_i & ready_o;
  assign w_pop   = valid_o & ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v     <= '0;
      r_count <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= RESET_VAL;
      end
    end else if (flush_i) begin
      // Flush drops every word but leaves the data registers untouched.
      r_v     <= '0;
      r_count <= '0;
    end else begin
      if (w_adv[0]) begin
        r_data[0] <= d_i;
        r_v[0]    <= valid_i;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (w_adv[k]) begin
          r_data[k] <= r_data[k-1];
          r_v[k]    <= r_v[k-1];
        end
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_register_pipe.sv
// Bench for register_pipe: directed vector table, hand sequences for flush and
// async reset, and random traffic checked against a queue-based timing model.
module tb_register_pipe;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [W-1:0]  d_i;
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  d_o;
  logic          valid_o;
  logic          ready_i;
  logic [CW-1:0] count_o;

  always #5 clk = ~clk;

  register_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL('0)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .d_i     (d_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .d_o     (d_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .count_o (count_o)
  );

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Model: a FIFO of words, each tagged with the earliest edge after which it
  // may be presented at the output (accept edge + D - 1).
  typedef struct {
    logic [W-1:0] data;
    int           avail;
  } word_t;
  word_t q[$];

  typedef struct {
    logic         fl;
    logic         v;
    logic [W-1:0] d;
    logic         r;
    logic         er;
    logic         ev;
    logic [W-1:0] ed;
    logic [CW-1:0] ec;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic fl, input logic v, input logic [W-1:0] d, input logic r);
    logic er, ev, push, pop;
    @(negedge clk);
    flush = fl; valid_i = v; d_i = d; ready_i = r;
    #1;
    er = !fl && ((q.size() < D) || r);
    ev = !fl && (q.size() > 0) && (q[0].avail <= edge_n);
    chk("ready_o", ready_o, er);
    chk("valid_o", valid_o, ev);
    if (ev) chk("d_o", d_o, q[0].data);
    chk("count_o", count_o, q.size());
    push = v && er;
    pop  = ev && r;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{d, edge_n + D - 1});
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid_i = 1'b0; d_i = '0; ready_i = 1'b0;

    // Backpressure: fill to D with sink stalled, then drain.
    //            fl  v   d     r   er  ev  ed    ec
    tbl[0]  = '{0, 1, 8'h10, 0, 1, 0, 8'h00, 3'd0};
    tbl[1]  = '{0, 1, 8'h11, 0, 1, 0, 8'h00, 3'd1};
    tbl[2]  = '{0, 1, 8'h12, 0, 1, 0, 8'h00, 3'd2};
    tbl[3]  = '{0, 1, 8'h13, 0, 1, 0, 8'h00, 3'd3};
    tbl[4]  = '{0, 1, 8'h14, 0, 0, 1, 8'h10, 3'd4};
    tbl[5]  = '{0, 1, 8'h14, 1, 1, 1, 8'h10, 3'd4};
    tbl[6]  = '{0, 0, 8'h00, 1, 1, 1, 8'h11, 3'd4};
    tbl[7]  = '{0, 0, 8'h00, 1, 1, 1, 8'h12, 3'd3};
    tbl[8]  = '{0, 0, 8'h00, 1, 1, 1, 8'h13, 3'd2};
    tbl[9]  = '{0, 0, 8'h00, 1, 1, 1, 8'h14, 3'd1};
    tbl[10] = '{0, 0, 8'h00, 1, 1, 0, 8'h00, 3'd0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_o", ready_o, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_valid_o", valid_o, 1'b0);
    chk("rst_d_o", d_o, 8'h00);
    chk("rst_count_o", count_o, 0);
    chk("rst_ready_o2", ready_o, 1'b1);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      flush = tbl[i].fl; valid_i = tbl[i].v; d_i = tbl[i].d; ready_i = tbl[i].r;
      #1;
      chk($sformatf("tbl%0d_ready_o", i), ready_o, tbl[i].er);
      chk($sformatf("tbl%0d_valid_o", i), valid_o, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("tbl%0d_d_o", i), d_o, tbl[i].ed);
      chk($sformatf("tbl%0d_count_o", i), count_o, tbl[i].ec);
    end

    // Full-throughput stream.
    for (int i = 1; i <= 10; i++) step(1'b0, 1'b1, W'(i), 1'b1);
    repeat (5) step(1'b0, 1'b0, 8'h00, 1'b1);

    // Bubble collapse under stall.
    step(1'b0, 1'b1, 8'h20, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h21, 1'b0);
    repeat (4) step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("bubble_count", count_o, 2);
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);

    // Flush with 3 words stored and a simultaneous input offer.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, W'(8'h40 + i), 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b1);
    repeat (6) step(1'b0, 1'b0, 8'h00, 1'b1);

    // Asynchronous reset between edges with the pipe full.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, W'(8'h30 + i), 1'b0);
    chk("pre_rst_count", count_o, 4);
    @(negedge clk);
    valid_i = 1'b0; ready_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid_o", valid_o, 1'b0);
    chk("async_rst_count_o", count_o, 0);
    chk("async_rst_ready_o", ready_o, 1'b1);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b1, 8'h77, 1'b1);
    repeat (5) step(1'b0, 1'b0, 8'h00, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 24) == 0), ($urandom_range(0, 9) < 7),
           W'($urandom), ($urandom_range(0, 9) < 6));
    end
    repeat (6) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("final_count", count_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
